lcd_bus_responder: RTL and testbench
====================================

// Module: lcd_bus_responder
// PURPOSE
//  Receiving end of the 8-bit character-LCD write bus (data, register-select, enable).
//  Decodes each write strobe as an HD44780-subset command or a character write.
//  Keeps a 2x16 shadow DDRAM, cursor and mode flags, exposed through a read port and status outputs.
//  Used as on-chip display model and scoreboard for the LCD controller; later feeds a VGA/UART mirror.
// PARAMETERS
//  CLEAR_CYCLES  32  busy cycles after Clear (0x01) and Return Home (0x02/0x03)
//  CMD_CYCLES    2   busy cycles after every other accepted strobe (>=1)
// PORTS
//  fpga_clk_i     in   1  single clock; all logic on posedge
//  fpga_reset_i   in   1  asynchronous, active-low reset
//  lcd_data_i     in   8  bus data byte
//  lcd_rs_i       in   1  0 = command, 1 = character data
//  lcd_en_i       in   1  enable; write strobe = registered 1->0 transition
//  rd_addr_i      in   5  {line, col[3:0]} shadow-DDRAM read address
//  rd_char_o      out  8  DDRAM byte at rd_addr_i, 1-cycle registered latency
//  valid_o        out  1  1-cycle pulse per accepted strobe (command or data)
//  busy_o         out  1  high while busy counter != 0
//  cursor_o       out  5  current {line, col}
//  display_on_o   out  1  D bit of last Display Control
//  two_line_o     out  1  N bit of last Function Set
//  drop_err_o     out  1  sticky: strobe arrived while busy
// BEHAVIOUR
//  Reset (async, low): DDRAM all 0x20; cursor 0; incr=1; display_on_o=0; two_line_o=0;
//   busy counter 0; rd_char_o=0x00; valid_o=0; drop_err_o=0; en_q=0.
//  Strobe: en_q <= lcd_en_i each cycle; strobe when en_q=1 && lcd_en_i=0.
//   Data and rs sampled in the strobe cycle.
//  Accept rule: strobe with busy counter==0 is accepted; valid_o pulses the next cycle.
//   Strobe with counter!=0 is discarded; drop_err_o set; no state change.
//   A strobe in the cycle the counter reaches 0 is still dropped (counter is checked pre-decrement).
//  Busy: on accept, counter <= CLEAR_CYCLES (Clear/Home) or CMD_CYCLES (others).
//   Decrements by 1 per cycle while nonzero.
//  Command decode, rs=0, priority by highest set bit:
//   1aaaaaaa  Set DDRAM addr: cursor <= {a[6], a[3:0]}; a[5:4] ignored.
//   001NFxxx  Function Set: two_line_o <= N.
//   01xxxxxx  Set CGRAM addr: accepted, busy, no other effect.
//   0001xxxx  Cursor/display shift: S/C=0 moves cursor +/-1 (R/L bit) with wrap rule; S/C=1 no effect.
//   00001DCB  Display Control: display_on_o <= D.
//   000001IS  Entry Mode: incr <= I; S ignored.
//   0000001x  Return Home: cursor <= 0; DDRAM unchanged.
//   00000001  Clear: DDRAM <= 0x20, all 32 bytes, in one cycle; cursor <= 0; incr <= 1.
//   00000000  NOP: accepted, CMD_CYCLES busy.
//  Data write, rs=1: DDRAM[cursor] <= lcd_data_i; then cursor steps per incr.
//  Cursor wrap, 5-bit: incr 0x0F->0x10 (line 1 col 0), 0x1F->0x00.
//   decr 0x00->0x1F, 0x10->0x0F. Same rule in all modes; two_line_o does not alter addressing.
//  Read port: rd_char_o <= DDRAM[rd_addr_i] every cycle.
//   Same-cycle write to that address returns the old value; the new value appears one cycle later.
//  drop_err_o cleared only by reset.
//  Reset mid-operation: all state returns to reset values immediately; an in-flight busy period is abandoned.
// TESTING
//  Reset, then read all 32 addresses -> every rd_char_o = 0x20; busy_o=0; cursor_o=0.
//  Strobe data 0x48,0x65,0x6C,0x6C,0x6F, each after busy_o falls ->
//   DDRAM[0..4]="Hello"; cursor_o=5; 5 valid_o pulses.
//  Cmd 0x8F; data 0x41, 0x42 -> DDRAM[0x0F]=0x41, DDRAM[0x10]=0x42; cursor_o=0x11.
//  Cmd 0x04 (decrement); cmd 0x80; data 0x5A -> DDRAM[0x00]=0x5A; cursor_o=0x1F.
//  Cmd 0x01; second strobe 5 cycles later -> second strobe dropped; drop_err_o=1;
//   busy_o high for 32 cycles; all bytes 0x20.
//  Cmd 0x0C, then 0x38 -> display_on_o=1, two_line_o=1.
//   Assert reset mid-busy -> busy_o=0 and flags cleared in the same cycle.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
//   Receiving end of an 8-bit character-LCD write bus. Each falling edge of the
//   enable line is decoded as an HD44780-subset command (rs=0) or a character
//   write (rs=1) into a 2x16 shadow DDRAM. Cursor, entry mode and display flags
//   are tracked so the block can serve as a display model / scoreboard.
//
// Ports
//   fpga_clk_i     in   clock, all logic on posedge
//   fpga_reset_i   in   asynchronous active-low reset
//   lcd_data_i     in   [7:0] bus data byte
//   lcd_rs_i       in   0 = command, 1 = character data
//   lcd_en_i       in   enable; a registered 1->0 transition is a write strobe
//   rd_addr_i      in   [4:0] {line, col} shadow-DDRAM read address
//   rd_char_o      out  [7:0] DDRAM byte at rd_addr_i, one cycle latency
//   valid_o        out  one-cycle pulse per accepted strobe
//   busy_o         out  high while the busy counter is nonzero
//   cursor_o       out  [4:0] current {line, col}
//   display_on_o   out  D bit of the last Display Control
//   two_line_o     out  N bit of the last Function Set
//   drop_err_o     out  sticky, a strobe arrived while busy
module lcd_bus_responder #(
  parameter int CLEAR_CYCLES = 32,
  parameter int CMD_CYCLES   = 2
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic [7:0] lcd_data_i,
  input  logic       lcd_rs_i,
  input  logic       lcd_en_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic [4:0] cursor_o,
  output logic       display_on_o,
  output logic       two_line_o,
  output logic       drop_err_o
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             r_en_q;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [7:0]       r_ddram [32];
  logic [4:0]       r_cursor;
  logic             r_incr;
  logic             r_display_on;
  logic             r_two_line;
  logic             r_drop_err;
  logic             r_valid;
  logic [7:0]       r_rd_char;

  logic             w_strobe;
  logic             w_idle;
  logic             w_accept;
  logic             w_is_clear;
  logic             w_is_home;
  logic [4:0]       w_cur_entry;
  logic [4:0]       w_cur_shift;

  assign w_strobe = r_en_q & ~lcd_en_i;
  // Counter is checked before its decrement, so a strobe landing on the
  // cycle it is at 1 is still dropped.
  assign w_idle   = (r_busy_cnt == '0);
  assign w_accept = w_strobe & w_idle;

  assign w_is_clear = ~lcd_rs_i & (lcd_data_i == 8'h01);
  assign w_is_home  = ~lcd_rs_i & (lcd_data_i[7:1] == 7'b0000001);

  // Plain 5-bit wrap gives 0x0F->0x10, 0x1F->0x00 and the reverse for decrement.
  assign w_cur_entry = r_incr        ? r_cursor + 5'd1 : r_cursor - 5'd1;
  assign w_cur_shift = lcd_data_i[2] ? r_cursor + 5'd1 : r_cursor - 5'd1;

  always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
    if (!fpga_reset_i) begin
      r_en_q       <= 1'b0;
      r_busy_cnt   <= '0;
      r_cursor     <= 5'd0;
      r_incr       <= 1'b1;
      r_display_on <= 1'b0;
      r_two_line   <= 1'b0;
      r_drop_err   <= 1'b0;
      r_valid      <= 1'b0;
      r_rd_char    <= 8'h00;
      for (int i = 0; i < 32; i++) begin
        r_ddram[i] <= 8'h20;
      end
    end else begin
      r_en_q    <= lcd_en_i;
      r_valid   <= w_accept;
      r_rd_char <= r_ddram[rd_addr_i];

      if (w_strobe && !w_idle) begin
        r_drop_err <= 1'b1;
      end

      if (w_accept) begin
        r_busy_cnt <= (w_is_clear || w_is_home) ? CNT_W'(CLEAR_CYCLES) : CNT_W'(CMD_CYCLES);

        if (lcd_rs_i) begin
          r_ddram[r_cursor] <= lcd_data_i;
          r_cursor          <= w_cur_entry;
        end else if (lcd_data_i[7]) begin
          // a[5:4] are not address bits in a 2x16 map
          r_cursor <= {lcd_data_i[6], lcd_data_i[3:0]};
        end else if (lcd_data_i[6]) begin
          // CGRAM address: busy period only
        end else if (lcd_data_i[5]) begin
          r_two_line <= lcd_data_i[3];
        end else if (lcd_data_i[4]) begin
          // S/C=1 (display shift) does not move the cursor
          if (!lcd_data_i[3]) begin
            r_cursor <= w_cur_shift;
          end
        end else if (lcd_data_i[3]) begin
          r_display_on <= lcd_data_i[2];
        end else if (lcd_data_i[2]) begin
          r_incr <= lcd_data_i[1];
        end else if (lcd_data_i[1]) begin
          r_cursor <= 5'd0;
        end else if (lcd_data_i[0]) begin
          r_cursor <= 5'd0;
          r_incr   <= 1'b1;
          for (int i = 0; i < 32; i++) begin
            r_ddram[i] <= 8'h20;
          end
        end
      end else if (!w_idle) begin
        r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
    end
  end

  assign rd_char_o    = r_rd_char;
  assign valid_o      = r_valid;
  assign busy_o       = ~w_idle;
  assign cursor_o     = r_cursor;
  assign display_on_o = r_display_on;
  assign two_line_o   = r_two_line;
  assign drop_err_o   = r_drop_err;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder
//   Directed bench for lcd_bus_responder: a table of bus writes with
//   hand-computed cursor/flag/busy expectations, followed by hand-written
//   sequences for the drop boundary, Clear, and reset during busy.
module tb_lcd_bus_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_char_o;
  logic       valid_o;
  logic       busy_o;
  logic [4:0] cursor_o;
  logic       display_on_o;
  logic       two_line_o;
  logic       drop_err_o;

  int n_chk  = 0;
  int n_fail = 0;

  lcd_bus_responder #(.CLEAR_CYCLES(32), .CMD_CYCLES(2)) dut (
    .fpga_clk_i   (clk),
    .fpga_reset_i (rst_n),
    .lcd_data_i   (lcd_data),
    .lcd_rs_i     (lcd_rs),
    .lcd_en_i     (lcd_en),
    .rd_addr_i    (rd_addr),
    .rd_char_o    (rd_char_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .cursor_o     (cursor_o),
    .display_on_o (display_on_o),
    .two_line_o   (two_line_o),
    .drop_err_o   (drop_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [4:0] cur;
    logic       disp;
    logic       two;
    int         busy;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Returns valid_o sampled on the negedge after the strobe edge.
  task automatic bus_write(input logic rs, input logic [7:0] d, output logic v);
    @(negedge clk);
    lcd_rs   = rs;
    lcd_data = d;
    lcd_en   = 1'b1;
    @(negedge clk);
    lcd_en   = 1'b0;
    @(negedge clk);
    v = valid_o;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("rd[%0h]", a), int'(rd_char_o), int'(e));
  endtask

  initial begin
    logic v;
    int   n;

    vt[0]  = '{1'b1, 8'h48, 5'h01, 1'b0, 1'b0, 2};
    vt[1]  = '{1'b1, 8'h65, 5'h02, 1'b0, 1'b0, 2};
    vt[2]  = '{1'b1, 8'h6C, 5'h03, 1'b0, 1'b0, 2};
    vt[3]  = '{1'b1, 8'h6C, 5'h04, 1'b0, 1'b0, 2};
    vt[4]  = '{1'b1, 8'h6F, 5'h05, 1'b0, 1'b0, 2};
    vt[5]  = '{1'b0, 8'h8F, 5'h0F, 1'b0, 1'b0, 2};
    vt[6]  = '{1'b1, 8'h41, 5'h10, 1'b0, 1'b0, 2};
    vt[7]  = '{1'b1, 8'h42, 5'h11, 1'b0, 1'b0, 2};
    vt[8]  = '{1'b0, 8'h04, 5'h11, 1'b0, 1'b0, 2};
    vt[9]  = '{1'b0, 8'h80, 5'h00, 1'b0, 1'b0, 2};
    vt[10] = '{1'b1, 8'h5A, 5'h1F, 1'b0, 1'b0, 2};
    vt[11] = '{1'b0, 8'h10, 5'h1E, 1'b0, 1'b0, 2};
    vt[12] = '{1'b0, 8'h14, 5'h1F, 1'b0, 1'b0, 2};
    vt[13] = '{1'b0, 8'h18, 5'h1F, 1'b0, 1'b0, 2};
    vt[14] = '{1'b0, 8'h06, 5'h1F, 1'b0, 1'b0, 2};
    vt[15] = '{1'b1, 8'h7A, 5'h00, 1'b0, 1'b0, 2};
    vt[16] = '{1'b0, 8'hFA, 5'h1A, 1'b0, 1'b0, 2};
    vt[17] = '{1'b0, 8'hB5, 5'h05, 1'b0, 1'b0, 2};
    vt[18] = '{1'b0, 8'h0C, 5'h05, 1'b1, 1'b0, 2};
    vt[19] = '{1'b0, 8'h20, 5'h05, 1'b1, 1'b0, 2};
    vt[20] = '{1'b0, 8'h38, 5'h05, 1'b1, 1'b1, 2};
    vt[21] = '{1'b0, 8'h08, 5'h05, 1'b0, 1'b1, 2};
    vt[22] = '{1'b0, 8'h0F, 5'h05, 1'b1, 1'b1, 2};
    vt[23] = '{1'b0, 8'h40, 5'h05, 1'b1, 1'b1, 2};
    vt[24] = '{1'b0, 8'h00, 5'h05, 1'b1, 1'b1, 2};
    vt[25] = '{1'b0, 8'h03, 5'h00, 1'b1, 1'b1, 32};

    rst_n    = 1'b0;
    lcd_data = 8'h00;
    lcd_rs   = 1'b0;
    lcd_en   = 1'b0;
    rd_addr  = 5'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_char", int'(rd_char_o), 8'h00);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_cursor", int'(cursor_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_drop", int'(drop_err_o), 0);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) rd_chk(5'(a), 8'h20);

    // Table of bus writes
    for (int i = 0; i < 26; i++) begin
      bus_write(vt[i].rs, vt[i].d, v);
      chk($sformatf("v%0d_valid", i), int'(v), 1);
      busy_len(n);
      chk($sformatf("v%0d_busy", i), n, vt[i].busy);
      chk($sformatf("v%0d_cursor", i), int'(cursor_o), int'(vt[i].cur));
      chk($sformatf("v%0d_disp", i), int'(display_on_o), int'(vt[i].disp));
      chk($sformatf("v%0d_two", i), int'(two_line_o), int'(vt[i].two));
    end

    rd_chk(5'h00, 8'h5A);
    rd_chk(5'h01, 8'h65);
    rd_chk(5'h02, 8'h6C);
    rd_chk(5'h03, 8'h6C);
    rd_chk(5'h04, 8'h6F);
    rd_chk(5'h05, 8'h20);
    rd_chk(5'h0F, 8'h41);
    rd_chk(5'h10, 8'h42);
    rd_chk(5'h11, 8'h20);
    rd_chk(5'h1F, 8'h7A);
    chk("drop_none", int'(drop_err_o), 0);

    // Strobe on the cycle the counter is at 1 is still dropped
    @(negedge clk);
    lcd_rs = 1'b0; lcd_data = 8'h0C; lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
    chk("bnd_first_valid", int'(valid_o), 1);
    lcd_rs = 1'b1; lcd_data = 8'h99; lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
    chk("bnd_second_valid", int'(valid_o), 0);
    chk("bnd_drop", int'(drop_err_o), 1);
    chk("bnd_busy", int'(busy_o), 0);
    chk("bnd_cursor", int'(cursor_o), 0);
    rd_chk(5'h00, 8'h5A);

    // Clear: restores incr, blanks DDRAM, 32 busy cycles, drops a mid-busy strobe
    bus_write(1'b0, 8'h04, v);
    busy_len(n);
    bus_write(1'b0, 8'h01, v);
    chk("clr_valid", int'(v), 1);
    busy_len(n);
    chk("clr_busy", n, 32);
    chk("clr_cursor", int'(cursor_o), 0);
    bus_write(1'b0, 8'h01, v);
    repeat (5) @(negedge clk);
    bus_write(1'b1, 8'h55, v);
    chk("clr_drop_valid", int'(v), 0);
    chk("clr_drop_err", int'(drop_err_o), 1);
    busy_len(n);
    chk("clr_drop_busy_end", int'(busy_o), 0);
    for (int a = 0; a < 32; a++) rd_chk(5'(a), 8'h20);
    bus_write(1'b1, 8'h31, v);
    chk("clr_incr_valid", int'(v), 1);
    busy_len(n);
    chk("clr_incr_cursor", int'(cursor_o), 1);
    rd_chk(5'h00, 8'h31);

    // Reset while busy
    bus_write(1'b0, 8'h01, v);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_disp", int'(display_on_o), 0);
    chk("mid_rst_two", int'(two_line_o), 0);
    chk("mid_rst_drop", int'(drop_err_o), 0);
    chk("mid_rst_cursor", int'(cursor_o), 0);
    chk("mid_rst_rd", int'(rd_char_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk(5'h00, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
